// File: rtl/cpu_pkg.sv
// Shared encodings for the load/store sequencer slice.
// Op codes, FSM states, register address width and latency counter width.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int LAT_W      = 8;

  typedef enum logic [1:0] {
    OP_ALU   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_NOP   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_LOAD_WAIT  = 2'b01,
    ST_STORE_WAIT = 2'b10
  } state_t;

endpackage

// File: rtl/hazard_unit.sv
// Combinational load-use / WAW hazard and write-port conflict detect.
// In: pending load, its rd, lat_is_two, decoded instr. Out: hazard, wb_conflict.
import cpu_pkg::*;

module hazard_unit (
  input  logic                  pending,
  input  logic [REG_ADDR_W-1:0] pend_rd,
  input  logic                  lat_is_two,
  input  logic [1:0]            instr_op,
  input  logic [REG_ADDR_W-1:0] instr_rd,
  input  logic [REG_ADDR_W-1:0] instr_rs1,
  input  logic [REG_ADDR_W-1:0] instr_rs2,
  output logic                  hazard,
  output logic                  wb_conflict
);

  logic is_alu;
  logic is_load;
  logic is_store;
  logic raw;
  logic waw;

  assign is_alu   = (instr_op == OP_ALU);
  assign is_load  = (instr_op == OP_LOAD);
  assign is_store = (instr_op == OP_STORE);

  assign raw = (pend_rd == instr_rs1) |
               ((pend_rd == instr_rs2) & is_store);
  assign waw = (pend_rd == instr_rd) & (is_alu | is_load);

  assign hazard = pending & (pend_rd != '0) & (raw | waw);

  // An ALU accepted now writes next cycle, which is the
  // load writeback cycle when lat_cnt is 2.
  assign wb_conflict = pending & lat_is_two & is_alu;

endmodule

// File: rtl/lsu_sequencer.sv
// Sequences ALU/LOAD/STORE into regFile and arbitrates its write port.
// In: instr_*, mem_ready. Out: accept, reg/mem strobes, busy, mem_err, counters.
import cpu_pkg::*;

module lsu_sequencer #(
  parameter int MEM_LAT = 2,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [1:0]       instr_op,
  input  logic [4:0]       instr_rd,
  input  logic [4:0]       instr_rs1,
  input  logic [4:0]       instr_rs2,
  input  logic             mem_ready,
  output logic             instr_accept,
  output logic             read_reg,
  output logic             write_reg,
  output logic             read_mem,
  output logic             write_mem,
  output logic             busy,
  output logic             mem_err,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt
);

  state_t                state;
  logic [LAT_W-1:0]      lat_cnt;
  logic                  pending;
  logic [REG_ADDR_W-1:0] pend_rd;
  logic                  hazard;
  logic                  wb_conflict;
  logic                  mem_block;

  hazard_unit u_hazard (
    .pending     (pending),
    .pend_rd     (pend_rd),
    .lat_is_two  (lat_cnt == LAT_W'(2)),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .hazard      (hazard),
    .wb_conflict (wb_conflict)
  );

  // Only one memory op in flight.
  assign mem_block = pending &
                     ((instr_op == OP_LOAD) |
                      (instr_op == OP_STORE));

  // Nothing is consumed while reset is held.
  assign instr_accept = reset & instr_valid &
                        ~hazard & ~wb_conflict &
                        ~mem_block &
                        (state != ST_STORE_WAIT);

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      pending   <= 1'b0;
      pend_rd   <= '0;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      read_mem  <= 1'b0;
      write_mem <= 1'b0;
      mem_err   <= 1'b0;
      load_cnt  <= '0;
      store_cnt <= '0;
    end else begin
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      read_mem  <= 1'b0;
      write_mem <= 1'b0;

      unique case (state)
        ST_LOAD_WAIT: begin
          if (lat_cnt == LAT_W'(1)) begin
            pending  <= 1'b0;
            load_cnt <= load_cnt + CNT_W'(1);
            state    <= ST_IDLE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        ST_STORE_WAIT: begin
          // mem_ready wins over a same-cycle expiry.
          if (mem_ready) begin
            store_cnt <= store_cnt + CNT_W'(1);
            state     <= ST_IDLE;
          end else if (lat_cnt == LAT_W'(1)) begin
            mem_err <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        default: ;
      endcase

      // LOAD/STORE only get here from IDLE, so the
      // state writes below never collide with above.
      if (instr_accept) begin
        unique case (instr_op)
          OP_ALU: begin
            read_reg  <= 1'b1;
            write_reg <= (instr_rd != '0);
          end
          OP_LOAD: begin
            read_mem <= 1'b1;
            pend_rd  <= instr_rd;
            pending  <= 1'b1;
            lat_cnt  <= LAT_W'(MEM_LAT);
            state    <= ST_LOAD_WAIT;
          end
          OP_STORE: begin
            write_mem <= 1'b1;
            lat_cnt   <= LAT_W'(TIMEOUT);
            state     <= ST_STORE_WAIT;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Self-checking bench for lsu_sequencer.
// Directed scenarios plus random traffic against a cycle-deadline model.
import cpu_pkg::*;

module tb_lsu_sequencer;

  localparam int MEM_LAT = 2;
  localparam int TIMEOUT = 15;
  localparam int CNT_W   = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             instr_valid = 1'b0;
  logic [1:0]       instr_op = OP_NOP;
  logic [4:0]       instr_rd = '0;
  logic [4:0]       instr_rs1 = '0;
  logic [4:0]       instr_rs2 = '0;
  logic             mem_ready = 1'b0;
  logic             instr_accept;
  logic             read_reg;
  logic             write_reg;
  logic             read_mem;
  logic             write_mem;
  logic             busy;
  logic             mem_err;
  logic [CNT_W-1:0] load_cnt;
  logic [CNT_W-1:0] store_cnt;

  int errors = 0;
  int checks = 0;

  lsu_sequencer #(
    .MEM_LAT (MEM_LAT),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_op     (instr_op),
    .instr_rd     (instr_rd),
    .instr_rs1    (instr_rs1),
    .instr_rs2    (instr_rs2),
    .mem_ready    (mem_ready),
    .instr_accept (instr_accept),
    .read_reg     (read_reg),
    .write_reg    (write_reg),
    .read_mem     (read_mem),
    .write_mem    (write_mem),
    .busy         (busy),
    .mem_err      (mem_err),
    .load_cnt     (load_cnt),
    .store_cnt    (store_cnt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic v, input logic [1:0] op,
                     input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2);
    instr_valid = v;
    instr_op    = op;
    instr_rd    = rd;
    instr_rs1   = rs1;
    instr_rs2   = rs2;
  endtask

  task automatic test_reset();
    logic [3:0] strobes;
    reset = 1'b0;
    mem_ready = 1'b0;
    put(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0);
    repeat (2) step();
    strobes = {read_reg, write_reg, read_mem, write_mem};
    checks++;
    if (strobes !== 4'b0) begin
      errors++;
      $display("FAIL rst_strobes: got %b want 0000", strobes);
    end
    checks++;
    if ({busy, mem_err} !== 2'b00) begin
      errors++;
      $display("FAIL rst_busy_err: got %b want 00", {busy, mem_err});
    end
    checks++;
    if (load_cnt !== '0 || store_cnt !== '0) begin
      errors++;
      $display("FAIL rst_cnt: got %0d/%0d want 0/0", load_cnt, store_cnt);
    end
    checks++;
    if (instr_accept !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_accept: got %b want 0", instr_accept);
    end
    // start a load then reset in the middle of it
    reset = 1'b1;
    put(1'b1, OP_LOAD, 5'd3, 5'd1, 5'd0);
    #1;
    checks++;
    if (instr_accept !== 1'b1) begin
      errors++;
      $display("FAIL rst_load_accept: got %b want 1", instr_accept);
    end
    step();
    checks++;
    if (read_mem !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_load_issue: got rm=%b busy=%b want 1 1", read_mem, busy);
    end
    reset = 1'b0;
    put(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0);
    repeat (3) step();
    strobes = {read_reg, write_reg, read_mem, write_mem};
    checks++;
    if (strobes !== 4'b0 || busy !== 1'b0 || load_cnt !== '0) begin
      errors++;
      $display("FAIL rst_mid_load: got strb=%b busy=%b lc=%0d want 0000 0 0",
               strobes, busy, load_cnt);
    end
    reset = 1'b1;
    step();
    checks++;
    if (write_reg !== 1'b0 || read_mem !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_release: got wr=%b rm=%b busy=%b want 0 0 0",
               write_reg, read_mem, busy);
    end
    repeat (3) step();
    checks++;
    if (load_cnt !== '0) begin
      errors++;
      $display("FAIL rst_abandon: got lc=%0d want 0", load_cnt);
    end
  endtask

  task automatic test_alu();
    put(1'b1, OP_ALU, 5'd5, 5'd1, 5'd2);
    #1;
    checks++;
    if (instr_accept !== 1'b1) begin
      errors++;
      $display("FAIL alu_accept: got %b want 1", instr_accept);
    end
    step();
    checks++;
    if (read_reg !== 1'b1 || write_reg !== 1'b1) begin
      errors++;
      $display("FAIL alu_rd5: got rr=%b wr=%b want 1 1", read_reg, write_reg);
    end
    put(1'b1, OP_ALU, 5'd0, 5'd1, 5'd2);
    step();
    checks++;
    if (read_reg !== 1'b1 || write_reg !== 1'b0) begin
      errors++;
      $display("FAIL alu_rd0: got rr=%b wr=%b want 1 0", read_reg, write_reg);
    end
    put(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0);
    step();
    checks++;
    if (read_reg !== 1'b0 || write_reg !== 1'b0) begin
      errors++;
      $display("FAIL alu_pulse: got rr=%b wr=%b want 0 0", read_reg, write_reg);
    end
  endtask

  task automatic test_load_use();
    int  stalls = 0;
    bit  got = 1'b0;
    put(1'b1, OP_LOAD, 5'd3, 5'd1, 5'd2);
    #1;
    step();
    checks++;
    if (read_mem !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lu_issue: got rm=%b busy=%b want 1 1", read_mem, busy);
    end
    put(1'b1, OP_ALU, 5'd9, 5'd3, 5'd2);
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      if (instr_accept === 1'b1) got = 1'b1;
      else begin
        stalls++;
        step();
      end
    end
    step();
    put(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0);
    checks++;
    if (!got || stalls != MEM_LAT) begin
      errors++;
      $display("FAIL lu_stall: got accepted=%0d stalls=%0d want 1 %0d",
               got, stalls, MEM_LAT);
    end
    checks++;
    if (load_cnt !== 16'd1 || write_reg !== 1'b1) begin
      errors++;
      $display("FAIL lu_after: got lc=%0d wr=%b want 1 1", load_cnt, write_reg);
    end
  endtask

  task automatic test_wb_conflict();
    put(1'b1, OP_LOAD, 5'd4, 5'd1, 5'd2);
    #1;
    step();
    put(1'b1, OP_ALU, 5'd7, 5'd1, 5'd2);
    #1;
    checks++;
    if (instr_accept !== 1'b0) begin
      errors++;
      $display("FAIL wbc_hold: got %b want 0", instr_accept);
    end
    step();
    #1;
    checks++;
    if (instr_accept !== 1'b1 || write_reg !== 1'b0) begin
      errors++;
      $display("FAIL wbc_release: got acc=%b wr=%b want 1 0", instr_accept, write_reg);
    end
    step();
    put(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0);
    checks++;
    if (write_reg !== 1'b1 || load_cnt !== 16'd2) begin
      errors++;
      $display("FAIL wbc_write: got wr=%b lc=%0d want 1 2", write_reg, load_cnt);
    end
    step();
  endtask

  task automatic test_store_ready();
    put(1'b1, OP_STORE, 5'd0, 5'd1, 5'd2);
    #1;
    checks++;
    if (instr_accept !== 1'b1) begin
      errors++;
      $display("FAIL st_accept: got %b want 1", instr_accept);
    end
    step();
    checks++;
    if (write_mem !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL st_issue: got wm=%b busy=%b want 1 1", write_mem, busy);
    end
    put(1'b1, OP_ALU, 5'd6, 5'd1, 5'd2);
    #1;
    checks++;
    if (instr_accept !== 1'b0) begin
      errors++;
      $display("FAIL st_block: got %b want 0", instr_accept);
    end
    repeat (3) step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    checks++;
    if (store_cnt !== 16'd1 || mem_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL st_done: got sc=%0d err=%b busy=%b want 1 0 0",
               store_cnt, mem_err, busy);
    end
    #1;
    checks++;
    if (instr_accept !== 1'b1) begin
      errors++;
      $display("FAIL st_next: got %b want 1", instr_accept);
    end
    step();
    // mem_ready arriving in the very last wait cycle
    put(1'b1, OP_STORE, 5'd0, 5'd1, 5'd2);
    #1;
    step();
    put(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0);
    repeat (TIMEOUT - 1) step();
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    checks++;
    if (store_cnt !== 16'd2 || mem_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL st_edge: got sc=%0d err=%b busy=%b want 2 0 0",
               store_cnt, mem_err, busy);
    end
  endtask

  task automatic test_store_timeout();
    put(1'b1, OP_STORE, 5'd0, 5'd1, 5'd2);
    #1;
    step();
    put(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0);
    repeat (TIMEOUT - 1) step();
    checks++;
    if (busy !== 1'b1 || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL to_wait: got busy=%b err=%b want 1 0", busy, mem_err);
    end
    step();
    checks++;
    if (mem_err !== 1'b1 || busy !== 1'b0 || store_cnt !== 16'd2) begin
      errors++;
      $display("FAIL to_expire: got err=%b busy=%b sc=%0d want 1 0 2",
               mem_err, busy, store_cnt);
    end
    put(1'b1, OP_NOP, 5'd0, 5'd0, 5'd0);
    #1;
    checks++;
    if (instr_accept !== 1'b1) begin
      errors++;
      $display("FAIL to_next: got %b want 1", instr_accept);
    end
    step();
    put(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    checks++;
    if (store_cnt !== 16'd2 || mem_err !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky: got sc=%0d err=%b want 2 1", store_cnt, mem_err);
    end
  endtask

  // Model: a load accepted in cycle a is pending through cycle
  // a+MEM_LAT (its writeback); a store accepted in cycle a waits
  // in cycles a+1..a+TIMEOUT for mem_ready.
  task automatic test_random();
    bit         m_ld = 0, m_st = 0, m_err = 0;
    int         m_wb = 0, m_dead = 0, m_cyc = 0;
    int         m_lc = 0, m_sc = 0;
    logic [4:0] m_prd = '0;
    bit         e_rr = 0, e_wr = 0, e_rm = 0, e_wm = 0;
    bit         haz, acc, v, rdy, rst;
    logic [1:0] op;
    logic [4:0] rd, rs1, rs2;
    logic [CNT_W-1:0] e_lc, e_sc;
    reset = 1'b0;
    put(1'b0, OP_NOP, 5'd0, 5'd0, 5'd0);
    repeat (2) step();
    for (int n = 0; n < 3000; n++) begin
      v   = ($urandom_range(0, 9) < 8);
      op  = 2'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 9) == 0);
      rst = (n < 2) ? 1'b1 : ($urandom_range(0, 199) != 0);
      reset = rst;
      mem_ready = rdy;
      put(v, op, rd, rs1, rs2);
      haz = m_ld && (
              (m_prd != 0 && (m_prd == rs1 ||
                              (op == OP_STORE && m_prd == rs2) ||
                              ((op == OP_ALU || op == OP_LOAD) && m_prd == rd))) ||
              op == OP_LOAD || op == OP_STORE ||
              (op == OP_ALU && m_cyc + 1 == m_wb));
      acc = rst && v && !m_st && !haz;
      #1;
      checks++;
      if (instr_accept !== acc) begin
        errors++;
        $display("FAIL rnd_accept n=%0d: got %b want %b", n, instr_accept, acc);
      end
      if (!rst) begin
        m_ld = 0; m_st = 0; m_err = 0; m_lc = 0; m_sc = 0;
        e_rr = 0; e_wr = 0; e_rm = 0; e_wm = 0;
      end else begin
        e_rr = acc && op == OP_ALU;
        e_wr = e_rr && rd != 0;
        e_rm = acc && op == OP_LOAD;
        e_wm = acc && op == OP_STORE;
        if (m_ld && m_cyc == m_wb) begin
          m_ld = 0;
          m_lc++;
        end
        if (m_st) begin
          if (rdy) begin
            m_st = 0;
            m_sc++;
          end else if (m_cyc == m_dead) begin
            m_st = 0;
            m_err = 1;
          end
        end
        if (e_rm) begin
          m_ld = 1;
          m_wb = m_cyc + MEM_LAT;
          m_prd = rd;
        end
        if (e_wm) begin
          m_st = 1;
          m_dead = m_cyc + TIMEOUT;
        end
      end
      m_cyc++;
      e_lc = m_lc[CNT_W-1:0];
      e_sc = m_sc[CNT_W-1:0];
      @(posedge clock);
      #1;
      checks++;
      if ({read_reg, write_reg, read_mem, write_mem} !==
          {e_rr, e_wr, e_rm, e_wm}) begin
        errors++;
        $display("FAIL rnd_strobes n=%0d: got %b want %b", n,
                 {read_reg, write_reg, read_mem, write_mem},
                 {e_rr, e_wr, e_rm, e_wm});
      end
      checks++;
      if (busy !== (m_ld | m_st) || mem_err !== m_err) begin
        errors++;
        $display("FAIL rnd_state n=%0d: got busy=%b err=%b want %b %b",
                 n, busy, mem_err, m_ld | m_st, m_err);
      end
      checks++;
      if (load_cnt !== e_lc || store_cnt !== e_sc) begin
        errors++;
        $display("FAIL rnd_cnt n=%0d: got %0d/%0d want %0d/%0d",
                 n, load_cnt, store_cnt, e_lc, e_sc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_use();
    test_wb_conflict();
    test_store_ready();
    test_store_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
